// File: rtl/simon_key_sched_stream_if.sv
// Round-key stream bundle between the Simon key expander and its consumer.
// Latency: none (wires only).
// Backpressure: rk_ready from the consumer holds the current round key in place.
interface simon_key_sched_stream_if #(
    parameter int N = 16,
    parameter int T = 32
);
    localparam int IW = $clog2(T);

    logic            start;
    logic [4*N-1:0]  key_in;
    logic            rk_valid;
    logic            rk_ready;
    logic [N-1:0]    rk;
    logic [IW-1:0]   rk_idx;
    logic            busy;
    logic            done;

    // Key expander side: sources the round-key stream.
    modport master (
        input  start, key_in, rk_ready,
        output rk_valid, rk, rk_idx, busy, done
    );

    // Consumer / controller side.
    modport slave (
        output start, key_in, rk_ready,
        input  rk_valid, rk, rk_idx, busy, done
    );
endinterface

// File: rtl/simon_key_sched_stream.sv
// Simon key expander: latches an M-word master key, streams round keys k[0..T-1].
// Latency: first key valid the edge after start, then one key per clock while accepted.
// Backpressure: rk/rk_idx/rk_valid hold while rk_ready is low; no comb path ready->valid.
module simon_key_sched_stream #(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int T    = 32,
    parameter int ZSEL = 0
) (
    input  logic clk,
    input  logic rst,
    simon_key_sched_stream_if.master bus
);
    localparam int IW = $clog2(T);
    localparam logic [IW-1:0] IDX_LAST = IW'(T - 1);

    if (!(N == 16 || N == 24 || N == 32 || N == 48 || N == 64)) begin : g_bad_n
        $error("simon_key_sched_stream: illegal word size N=%0d", N);
    end
    if (!(M == 2 || M == 3 || M == 4)) begin : g_bad_m
        $error("simon_key_sched_stream: illegal key word count M=%0d", M);
    end
    if (!(T > M && T <= 72)) begin : g_bad_t
        $error("simon_key_sched_stream: illegal round count T=%0d", T);
    end
    if (ZSEL < 0 || ZSEL > 4) begin : g_bad_z
        $error("simon_key_sched_stream: illegal z-sequence select ZSEL=%0d", ZSEL);
    end

    // z sequences written first element leftmost, so element i lives at bit 61-i.
    function automatic logic [61:0] z_seq(input int sel);
        case (sel)
            0:       return 62'b11111010001001010110000111001101111101000100101011000011100110;
            1:       return 62'b10001110111110010011000010110101000111011111001001100001011010;
            2:       return 62'b10101111011100000011010010011000101000010001111110010110110011;
            3:       return 62'b11011011101011000110010111100000010010001010011100110100001111;
            4:       return 62'b11010001111001101011011000100000010111000011001010010011101111;
            default: return '0;
        endcase
    endfunction

    localparam logic [61:0] Z_SEQ = z_seq(ZSEL);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  w [M];
    logic [IW-1:0] rk_idx_q;
    logic          done_q;
    logic          load, shift, fin;
    logic [N-1:0]  tmp, new_w;
    logic [6:0]    zi;
    logic [5:0]    zpos;
    logic          unused_key;

    // Only the top M*N key bits form the key; the rest are deliberately ignored.
    assign unused_key = ^bus.key_in;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and window control: load on accepted start, shift on each non-final handshake.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (bus.rk_ready) begin
                    if (rk_idx_q == IDX_LAST) begin
                        state_nxt = IDLE;
                        fin       = 1'b1;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next key word k[i+M] from the window holding k[i..i+M-1], i = rk_idx_q.
    always_comb begin
        tmp = {w[M-1][2:0], w[M-1][N-1:3]};
        if (M == 4) tmp = tmp ^ w[1];
        tmp = tmp ^ {tmp[0], tmp[N-1:1]};
        zi  = 7'(rk_idx_q);
        if (zi >= 7'd62) zpos = 6'(7'd123 - zi);
        else             zpos = 6'(7'd61 - zi);
        new_w = ~w[0] ^ tmp ^ N'(3) ^ N'(Z_SEQ[zpos]);
    end

    // Key window, round index and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_idx_q <= '0;
            done_q   <= 1'b0;
            for (int j = 0; j < M; j++) w[j] <= '0;
        end else begin
            done_q <= fin;
            if (load) begin
                rk_idx_q <= '0;
                for (int j = 0; j < M; j++) w[j] <= bus.key_in[(4*N-1)-j*N -: N];
            end else if (shift) begin
                rk_idx_q <= rk_idx_q + IW'(1);
                for (int j = 0; j < M - 1; j++) w[j] <= w[j+1];
                w[M-1] <= new_w;
            end
        end
    end

    assign bus.rk       = w[0];
    assign bus.rk_idx   = rk_idx_q;
    assign bus.rk_valid = (state == RUN);
    assign bus.busy     = (state == RUN);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_simon_key_sched_stream.sv
// Bench for simon_key_sched_stream: all ten standard Simon configurations side by side.
// Each instance is checked every cycle against a whole-schedule reference model.
// Instance 0 additionally runs directed scenarios with literal expectations.
module tb_simon_key_sched_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit fin [10];
    logic [63:0] kexp [10][72];

    function automatic int cfg_n(input int g);
        case (g)
            0: return 16; 1: return 24; 2: return 24; 3: return 32; 4: return 32;
            5: return 48; 6: return 48; default: return 64;
        endcase
    endfunction
    function automatic int cfg_m(input int g);
        case (g)
            0: return 4; 1: return 3; 2: return 4; 3: return 3; 4: return 4;
            5: return 2; 6: return 3; 7: return 2; 8: return 3; default: return 4;
        endcase
    endfunction
    function automatic int cfg_t(input int g);
        case (g)
            0: return 32; 1: return 36; 2: return 36; 3: return 42; 4: return 44;
            5: return 52; 6: return 54; 7: return 68; 8: return 69; default: return 72;
        endcase
    endfunction
    function automatic int cfg_z(input int g);
        case (g)
            0: return 0; 1: return 0; 2: return 1; 3: return 2; 4: return 3;
            5: return 2; 6: return 3; 7: return 2; 8: return 3; default: return 4;
        endcase
    endfunction

    function automatic logic zbit(input int z, input int i);
        string s;
        case (z)
            0:       s = "11111010001001010110000111001101111101000100101011000011100110";
            1:       s = "10001110111110010011000010110101000111011111001001100001011010";
            2:       s = "10101111011100000011010010011000101000010001111110010110110011";
            3:       s = "11011011101011000110010111100000010010001010011100110100001111";
            default: s = "11010001111001101011011000100000010111000011001010010011101111";
        endcase
        return (s[i] == "1");
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n,
                                        input logic [63:0] mask);
        return ((x >> r) | (x << (n - r))) & mask;
    endfunction

    // Whole key schedule for configuration g, straight from the Simon recurrence.
    task automatic expand(input int g, input int n, input int m, input int t, input int z,
                          input logic [255:0] key);
        logic [63:0] mask, tmp;
        mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        for (int j = 0; j < m; j++) kexp[g][j] = (key >> (4*n - (j+1)*n)) & mask;
        for (int i = m; i < t; i++) begin
            tmp = ror(kexp[g][i-1], 3, n, mask);
            if (m == 4) tmp = tmp ^ kexp[g][i-3];
            tmp = tmp ^ ror(tmp, 1, n, mask);
            kexp[g][i] = (~kexp[g][i-m] ^ tmp ^ 64'(zbit(z, (i - m) % 62)) ^ 64'd3) & mask;
        end
    endtask

    task automatic check(input string nm, input int g, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cfg%0d at %0t: got %0h, expected %0h", nm, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 10; g++) begin : cfg
        localparam int N = cfg_n(g);
        localparam int M = cfg_m(g);
        localparam int T = cfg_t(g);
        localparam int Z = cfg_z(g);

        logic rst = 1'b1;
        simon_key_sched_stream_if #(.N(N), .T(T)) bus ();
        simon_key_sched_stream #(.N(N), .M(M), .T(T), .ZSEL(Z)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Reference: is a run active, which key index is on offer, did a run just end.
        bit m_busy = 1'b0;
        bit m_done = 1'b0;
        int m_idx  = 0;

        always @(posedge clk) begin
            if (rst) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
                m_idx  <= 0;
            end else begin
                m_done <= 1'b0;
                if (!m_busy) begin
                    if (bus.start) begin
                        expand(g, N, M, T, Z, 256'(bus.key_in));
                        m_busy <= 1'b1;
                        m_idx  <= 0;
                    end
                end else if (bus.rk_ready) begin
                    if (m_idx == T - 1) begin
                        m_busy <= 1'b0;
                        m_done <= 1'b1;
                    end else begin
                        m_idx <= m_idx + 1;
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                check("rk_valid", g, 64'(bus.rk_valid), 64'(m_busy));
                check("busy", g, 64'(bus.busy), 64'(m_busy));
                check("done", g, 64'(bus.done), 64'(m_done));
                if (m_busy) begin
                    check("rk", g, 64'(bus.rk), kexp[g][m_idx]);
                    check("rk_idx", g, 64'(bus.rk_idx), 64'(m_idx));
                end
            end
        end

        if (g != 0) begin : g_rnd
            initial begin
                logic [255:0] kr;
                int cyc;
                bus.start = 1'b0; bus.key_in = '0; bus.rk_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                for (int r = 0; r < 3; r++) begin
                    kr = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
                    bus.key_in = kr[4*N-1:0];
                    bus.start  = 1'b1;
                    @(posedge clk); #1;
                    kr = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
                    bus.key_in = kr[4*N-1:0];
                    cyc = 0;
                    while (!bus.done && cyc < 1000) begin
                        bus.rk_ready = ($urandom_range(0, 3) != 0);
                        bus.start    = ($urandom_range(0, 7) == 0);
                        @(posedge clk); #1;
                        cyc++;
                    end
                    check("run_completes", g, 64'(bus.done), 64'd1);
                    bus.start = 1'b0;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                repeat (2) @(posedge clk);
                fin[g] = 1'b1;
            end
        end else begin : g_dir
            initial begin
                logic [15:0] lit [5];
                logic [255:0] kr;
                int cyc;
                lit = '{16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3};
                bus.start = 1'b0; bus.key_in = '0; bus.rk_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("rst_rk_valid", 0, 64'(bus.rk_valid), 64'd0);
                check("rst_busy", 0, 64'(bus.busy), 64'd0);
                check("rst_done", 0, 64'(bus.done), 64'd0);
                check("rst_rk", 0, 64'(bus.rk), 64'd0);
                check("rst_rk_idx", 0, 64'(bus.rk_idx), 64'd0);
                rst = 1'b0;

                // Reference vector, full-speed consumer, start->done timing.
                bus.key_in = 64'h0100_0908_1110_1918; bus.start = 1'b1; bus.rk_ready = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0; bus.key_in = 64'hDEAD_BEEF_CAFE_F00D;
                cyc = 1;
                while (!bus.done && cyc < 200) begin
                    if (cyc <= 5) check("vector_rk", 0, 64'(bus.rk), 64'(lit[cyc-1]));
                    @(posedge clk); #1;
                    cyc++;
                end
                check("start_to_done_cycles", 0, 64'(cyc), 64'd33);
                check("done_cycle_busy", 0, 64'(bus.busy), 64'd0);
                check("done_cycle_rk_valid", 0, 64'(bus.rk_valid), 64'd0);
                for (int j = 0; j < 5; j++) check("model_pin", 0, kexp[0][j], 64'(lit[j]));
                @(posedge clk); #1;
                check("done_one_cycle", 0, 64'(bus.done), 64'd0);

                // Second run: stray start at idx 5, stall at idx 10, restart in the done cycle.
                bus.key_in = 64'h0100_0908_1110_1918; bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                cyc = 0;
                while (!(bus.rk_valid && bus.rk_idx == 5'd5) && cyc < 100) begin
                    @(posedge clk); #1; cyc++;
                end
                check("reach_idx5", 0, 64'(bus.rk_idx), 64'd5);
                bus.key_in = 64'h5555_AAAA_3333_CCCC; bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                cyc = 0;
                while (!(bus.rk_valid && bus.rk_idx == 5'd10) && cyc < 100) begin
                    @(posedge clk); #1; cyc++;
                end
                bus.rk_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk); #1;
                    check("stall_idx", 0, 64'(bus.rk_idx), 64'd10);
                    check("stall_valid", 0, 64'(bus.rk_valid), 64'd1);
                end
                bus.rk_ready = 1'b1;
                cyc = 0;
                while (!bus.done && cyc < 100) begin @(posedge clk); #1; cyc++; end
                check("run2_done", 0, 64'(bus.done), 64'd1);
                bus.key_in = 64'h1234_5678_9ABC_DEF0; bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                check("b2b_valid", 0, 64'(bus.rk_valid), 64'd1);
                check("b2b_idx", 0, 64'(bus.rk_idx), 64'd0);
                check("b2b_rk", 0, 64'(bus.rk), 64'h1234);

                // Reset in the middle of a run, then a fresh start.
                cyc = 0;
                while (!(bus.rk_valid && bus.rk_idx == 5'd12) && cyc < 100) begin
                    @(posedge clk); #1; cyc++;
                end
                check("reach_idx12", 0, 64'(bus.rk_idx), 64'd12);
                rst = 1'b1;
                @(posedge clk); #1;
                check("midrst_valid", 0, 64'(bus.rk_valid), 64'd0);
                check("midrst_busy", 0, 64'(bus.busy), 64'd0);
                check("midrst_done", 0, 64'(bus.done), 64'd0);
                check("midrst_idx", 0, 64'(bus.rk_idx), 64'd0);
                rst = 1'b0;
                bus.key_in = 64'h0100_0908_1110_1918; bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                check("fresh_rk", 0, 64'(bus.rk), 64'h0100);
                check("fresh_idx", 0, 64'(bus.rk_idx), 64'd0);
                cyc = 0;
                while (!bus.done && cyc < 100) begin @(posedge clk); #1; cyc++; end
                bus.key_in = '0;

                // Random keys with a random-ready consumer.
                for (int r = 0; r < 3; r++) begin
                    kr = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
                    bus.key_in = kr[4*N-1:0];
                    bus.start  = 1'b1;
                    @(posedge clk); #1;
                    bus.key_in = ~kr[4*N-1:0];
                    cyc = 0;
                    while (!bus.done && cyc < 1000) begin
                        bus.rk_ready = ($urandom_range(0, 3) != 0);
                        bus.start    = ($urandom_range(0, 7) == 0);
                        @(posedge clk); #1;
                        cyc++;
                    end
                    check("run_completes", 0, 64'(bus.done), 64'd1);
                    bus.start = 1'b0;
                end
                repeat (2) @(posedge clk);
                fin[0] = 1'b1;
            end
        end
    end

    initial begin
        int cyc;
        bit all;
        cyc = 0;
        all = 1'b0;
        while (!all && cyc < 20000) begin
            @(posedge clk);
            cyc++;
            all = 1'b1;
            for (int i = 0; i < 10; i++) if (!fin[i]) all = 1'b0;
        end
        check("all_configs_finished", -1, 64'(all), 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
